// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg
//   Shared types and defaults for the counter_monitor slice.
//   - state_t        : monitor FSM states
//   - DEF_*          : default parameter values for the top level
//   - RUN_W          : width of the consecutive-increment run counter
//   Optional feature macro used by this slice: COUNTER_MONITOR_WRAP_EN.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH       = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 2;
  localparam int unsigned DEF_ERR_W       = 8;

  // Run counter holds up to 15 consecutive increments (LOCK_CYCLES 1..15).
  localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// sat_counter
//   Saturating statistics counter. Clear wins over a simultaneous
//   increment; the count sticks at all-ones and never wraps.
//   Ports:
//     clk    in  1  rising-edge clock
//     rst_n  in  1  asynchronous active-low reset
//     inc    in  1  increment request
//     clr    in  1  synchronous clear (priority over inc)
//     cnt    out W  registered count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// counter_monitor
//   Observer for a free-running modulo-2^WIDTH up-counter. The observed
//   bus is registered (samp), then compared against the previous sample
//   (prev). The FSM acquires lock after LOCK_CYCLES consecutive correct
//   increments, and while locked reports each mismatch as a one-cycle
//   error pulse plus a saturating error count.
//   Optional macro COUNTER_MONITOR_WRAP_EN adds a saturating count of
//   max-to-0 wraps seen while locked (port output_wrapcnt_0_8).
//   Ports:
//     input_clock1_1      in  1      rising-edge clock
//     input_reset_n1_2    in  1      asynchronous active-low reset
//     input_count_0_3     in  WIDTH  observed counter value
//     input_clear_0_4     in  1      synchronous clear of statistics
//     output_locked_0_5   out 1      sequence locked
//     output_error_0_6    out 1      one-cycle mismatch pulse
//     output_errcnt_0_7   out ERR_W  saturating mismatch count
//     output_wrapcnt_0_8  out ERR_W  saturating wrap count (macro only)
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned ERR_W       = DEF_ERR_W
) (
  input  logic             input_clock1_1,
  input  logic             input_reset_n1_2,
  input  logic [WIDTH-1:0] input_count_0_3,
  input  logic             input_clear_0_4,
  output logic             output_locked_0_5,
  output logic             output_error_0_6,
  output logic [ERR_W-1:0] output_errcnt_0_7
`ifdef COUNTER_MONITOR_WRAP_EN
  ,
  output logic [ERR_W-1:0] output_wrapcnt_0_8
`endif
);

  state_t           state;
  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expect_next;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic             match;
  logic             err_inc;

  // Increment is computed at WIDTH bits so max+1 wraps to 0 and matches.
  assign expect_next = prev + WIDTH'(1);
  assign match       = (samp == expect_next);
  assign run_inc     = run + RUN_W'(1);
  assign err_inc     = (state == LOCKED) && !match;

  always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
    if (!input_reset_n1_2) begin
      state             <= UNLOCKED;
      samp              <= '0;
      prev              <= '0;
      run               <= '0;
      output_locked_0_5 <= 1'b0;
      output_error_0_6  <= 1'b0;
    end else begin
      samp             <= input_count_0_3;
      // Every evaluation re-references, so a bad sample becomes the new base.
      prev             <= samp;
      output_error_0_6 <= 1'b0;
      case (state)
        UNLOCKED: begin
          run   <= '0;
          state <= ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            run <= run_inc;
            if (run_inc == RUN_W'(LOCK_CYCLES)) begin
              state             <= LOCKED;
              output_locked_0_5 <= 1'b1;
            end
          end else begin
            run <= '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            output_error_0_6  <= 1'b1;
            output_locked_0_5 <= 1'b0;
            run               <= '0;
            state             <= ACQUIRE;
          end
        end
        default: begin
          state <= UNLOCKED;
        end
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_errcnt (
    .clk   (input_clock1_1),
    .rst_n (input_reset_n1_2),
    .inc   (err_inc),
    .clr   (input_clear_0_4),
    .cnt   (output_errcnt_0_7)
  );

`ifdef COUNTER_MONITOR_WRAP_EN
  logic wrap_inc;

  // Only wraps observed while already locked count; the acquiring edge never does.
  assign wrap_inc = (state == LOCKED) && match && (prev == '1) && (samp == '0);

  sat_counter #(.W(ERR_W)) u_wrapcnt (
    .clk   (input_clock1_1),
    .rst_n (input_reset_n1_2),
    .inc   (wrap_inc),
    .clr   (input_clear_0_4),
    .cnt   (output_wrapcnt_0_8)
  );
`else
  // Wrap counting not built.
`endif

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Self-checking observer for the free-running binary counter designs. It samples the counter's output bus on every clock and locks onto the counting sequence. Once locked, it flags any deviation from modulo-2^WIDTH up-counting, counts errors and counter wrap-arounds, and exposes pass/fail status to the surrounding test circuit. It sits downstream of the counter as its consumer, driven by the same clock.

## Interface
- WIDTH, 3: width of the observed count bus.
- LOCK_CYCLES, 2: number of consecutive correct increments required to declare lock; range 1..15.
- ERR_W, 8: width of the error and wrap counters.
- input_clock1_1  in  1  single clock; all logic is on the rising edge.
- input_reset_n1_2  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is seen at the next rising edge.
- input_count_0_3  in  WIDTH  observed counter value; the MSB is LED1.
- input_clear_0_4  in  1  synchronous clear of both statistics counters.
- output_locked_0_5  out  1  high while the sequence is locked.
- output_error_0_6  out  1  one-cycle pulse on each detected mismatch.
- output_errcnt_0_7  out  ERR_W  saturating mismatch count.
- output_wrapcnt_0_8  out  ERR_W  saturating count of max-to-0 wraps; present only with the macro (see Configuration).

## Operation
- Reset (asynchronous, active-low) forces the following:
  - state = UNLOCKED, run = 0, prev = 0, sample register = 0.
  - All outputs = 0.
- Stage 1: input_count_0_3 is registered into samp every edge.
- Stage 2 evaluates samp against prev. A match means samp == (prev + 1) mod 2^WIDTH; max+1 wraps to 0 and counts as a match.
- FSM states:
  - UNLOCKED: store prev = samp, set run = 0, go to ACQUIRE. No error is reported.
  - ACQUIRE, on match: run++. When run reaches LOCK_CYCLES, go to LOCKED and set output_locked_0_5 = 1.
  - ACQUIRE, on mismatch: run = 0 and stay in ACQUIRE. No error pulse and no error count.
  - LOCKED, on match: stay in LOCKED. If prev == 2^WIDTH-1 and samp == 0, wrapcnt++.
  - LOCKED, on mismatch: output_error_0_6 = 1 for one cycle, errcnt++, locked = 0, run = 0, go to ACQUIRE.
- prev = samp is updated on every evaluation, in every state.
- Resynchronisation: after a mismatch, the erroneous sample becomes the new reference.
- Saturation: errcnt and wrapcnt stop at 2^ERR_W-1 and never wrap.
- Clear: input_clear_0_4 high at an edge zeroes errcnt and wrapcnt. Clear has priority over a simultaneous increment, so the result is 0, not 1. Clear does not affect state, locked, prev or the error pulse.
- Wraps are counted only when the state was LOCKED at the evaluation. The lock-acquiring transition never counts a wrap.

## Timing
- Latency: a value presented before edge n is registered at edge n and evaluated at edge n+1. Outputs therefore change 2 edges after the input.
- Lock: with the first sample registered at edge E, output_locked_0_5 rises after edge E+1+LOCK_CYCLES (E+3 for the default).
- Error pulse: exactly one cycle wide. Back-to-back mismatches cannot pulse twice in a row, because the state leaves LOCKED.
- Reset mid-operation: all state and counters are lost immediately, with no partial update. Relock requires the full acquire sequence.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- COUNTER_MONITOR_WRAP_EN
  - Defined: output_wrapcnt_0_8 and its counter are implemented as described above.
  - Undefined: the port, counter and wrap-detect logic are all absent. Every other behaviour is unchanged.

## Structure
- counter_monitor_pkg holds:
  - the state enum (UNLOCKED, ACQUIRE, LOCKED);
  - default constants DEF_WIDTH = 3, DEF_LOCK_CYCLES = 2, DEF_ERR_W = 8;
  - the run-counter width constant (4 bits).
- Sub-module sat_counter (parameter W) implements each statistics counter, with inputs inc and clr, clr-priority and saturation. It is instantiated once for errors and once for wraps under the macro.
- The top level contains the sample register, match compare and FSM.

## Test plan
- Reset, then count 0,1,2,3… every cycle: locked = 0 through the edge after the 2nd increment. After that, locked = 1, error stays 0 and errcnt = 0.
- Locked, then inject 5,6,7,0,1: no error; wrapcnt goes 0→1 on the 7→0 step (macro defined).
- Locked at 3, then present 6 instead of 4: a one-cycle error pulse, errcnt = 1 and locked = 0. Continuing 7,0,1 relocks after the 2nd increment, with no further errors.
- ERR_W = 2, repeatedly relock and glitch 5 times: errcnt reads 1,2,3,3,3. Then assert clear during a glitch: errcnt = 0.
- Reset asserted mid-count while locked with errcnt = 2: all outputs are 0 immediately. After release, the first sample produces no error.
- Build without COUNTER_MONITOR_WRAP_EN: the port list has no output_wrapcnt_0_8, and the scenarios above match except for the wrap checks.
